// File: rtl/step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : step_ctrl
// Purpose  : Instruction sequencer for the demo computer datapath. Fetches a
//            32-bit word at pc, drives the shared ALU, holds an 8-entry
//            register file (r0 hard-wired to zero) and writes results back.
//            One instruction is started per run tick or single-step pulse.
//
// Ports    : sys_clk     in   1   system clock, rising edge
//            sys_rst     in   1   asynchronous reset, active low
//            tick        in   1   one-cycle divider pulse
//            run         in   1   level, start on every tick when high
//            step        in   1   one-cycle single-step pulse
//            mem_addr    out  32  program memory address (== pc)
//            mem_data    in   32  combinational read data
//            alu_cmd     out  5   ALU function code
//            alu_a       out  32  ALU operand A
//            alu_b       out  32  ALU operand B
//            alu_result  in   32  combinational ALU output
//            pc          out  32  current byte address (multiple of 4)
//            disp        out  32  last value written to a nonzero register
//            busy        out  1   high in FETCH, EXEC, WB
//            halted      out  1   high in HALT
//
// Config   : STEP_CTRL_BRANCH_EN - when defined op 10 is a jump to imm & ~3;
//            otherwise op 10 is a NOP that just advances pc.
//
// Revision : 1.0 - initial release
// ============================================================================
module step_ctrl #(
    parameter int unsigned MEM_SIZE = 64
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        tick,
    input  logic        run,
    input  logic        step,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic [4:0]  alu_cmd,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    output logic [31:0] pc,
    output logic [31:0] disp,
    output logic        busy,
    output logic        halted
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0]  C_OP_RR   = 2'b00;
    localparam logic [1:0]  C_OP_RI   = 2'b01;
    localparam logic [1:0]  C_OP_JMP  = 2'b10;
    localparam logic [1:0]  C_OP_HALT = 2'b11;

    localparam logic [31:0] C_MEM_LAST = 32'(MEM_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WB    = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    state_t      r_state;
    state_t      w_next_state;

    // Only the instruction fields needed after FETCH are kept; operands and
    // function code go straight into the ALU output registers.
    logic [1:0]  r_op;
    logic [2:0]  r_rd;
    logic [31:0] r_result;
    logic [31:0] r_rf [0:7];

    logic        w_start;
    logic [1:0]  w_f_op;
    logic [4:0]  w_f_fn;
    logic [2:0]  w_f_rs1;
    logic [2:0]  w_f_rs2;
    logic [15:0] w_f_imm;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic        w_alu_op;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_seq;

`ifdef STEP_CTRL_BRANCH_EN
    logic [15:0] r_imm;
    logic [31:0] w_jmp_raw;
    logic [31:0] w_pc_jmp;
`endif

    // ------------------------------------------------------------------------
    // Decode of the word presented in FETCH
    // ------------------------------------------------------------------------
    assign w_f_op  = mem_data[31:30];
    assign w_f_fn  = mem_data[29:25];
    assign w_f_rs1 = mem_data[21:19];
    assign w_f_rs2 = mem_data[18:16];
    assign w_f_imm = mem_data[15:0];

    assign w_alu_op = (w_f_op == C_OP_RR) || (w_f_op == C_OP_RI);

    // r0 always reads as zero regardless of array contents.
    always_comb begin
        w_rs1_val = '0;
        w_rs2_val = '0;
        if (w_f_rs1 != 3'd0) begin
            w_rs1_val = r_rf[w_f_rs1];
        end
        if (w_f_rs2 != 3'd0) begin
            w_rs2_val = r_rf[w_f_rs2];
        end
    end

    // Any start source in IDLE launches exactly one instruction; pulses in
    // other states are simply not looked at, so they are dropped.
    assign w_start = step | (run & tick);

    // ------------------------------------------------------------------------
    // Next-pc computation
    // ------------------------------------------------------------------------
    assign w_pc_plus4 = pc + 32'd4;
    assign w_pc_seq   = (w_pc_plus4 > C_MEM_LAST) ? 32'd0 : w_pc_plus4;

`ifdef STEP_CTRL_BRANCH_EN
    assign w_jmp_raw = {16'd0, r_imm[15:2], 2'b00};
    assign w_pc_jmp  = (w_jmp_raw > C_MEM_LAST) ? 32'd0 : w_jmp_raw;
`endif

    assign mem_addr = pc;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        halted       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                busy         = 1'b1;
                w_next_state = S_EXEC;
            end
            S_EXEC: begin
                busy = 1'b1;
                if (r_op == C_OP_HALT) begin
                    w_next_state = S_HALT;
                end else begin
                    w_next_state = S_WB;
                end
            end
            S_WB: begin
                busy         = 1'b1;
                w_next_state = S_IDLE;
            end
            S_HALT: begin
                halted       = 1'b1;
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_op     <= C_OP_RR;
            r_rd     <= 3'd0;
            r_result <= '0;
            alu_cmd  <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            pc       <= '0;
            disp     <= '0;
`ifdef STEP_CTRL_BRANCH_EN
            r_imm    <= '0;
`endif
            for (int i = 0; i < 8; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_op <= w_f_op;
                    r_rd <= mem_data[24:22];
`ifdef STEP_CTRL_BRANCH_EN
                    r_imm <= w_f_imm;
`endif
                    // ALU outputs change only on entry to EXEC, and only for
                    // instructions that actually use the ALU.
                    if (w_alu_op) begin
                        alu_cmd <= w_f_fn;
                        alu_a   <= w_rs1_val;
                        alu_b   <= (w_f_op == C_OP_RR) ? w_rs2_val
                                                       : {16'd0, w_f_imm};
                    end
                end
                S_EXEC: begin
                    r_result <= alu_result;
                end
                S_WB: begin
                    case (r_op)
                        C_OP_RR, C_OP_RI: begin
                            if (r_rd != 3'd0) begin
                                r_rf[r_rd] <= r_result;
                                disp       <= r_result;
                            end
                            pc <= w_pc_seq;
                        end
                        C_OP_JMP: begin
`ifdef STEP_CTRL_BRANCH_EN
                            pc <= w_pc_jmp;
`else
                            pc <= w_pc_seq;
`endif
                        end
                        default: begin
                            pc <= pc;
                        end
                    endcase
                end
                default: begin
                    r_op <= r_op;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_ctrl
// Purpose  : Directed self-checking bench for step_ctrl with a small program
//            memory and a four-function ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_step_ctrl;

    localparam logic [4:0] F_ADD = 5'd0;
    localparam logic [4:0] F_SUB = 5'd1;
    localparam logic [4:0] F_AND = 5'd2;
    localparam logic [4:0] F_OR  = 5'd3;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        tick    = 1'b0;
    logic        run     = 1'b0;
    logic        step    = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [4:0]  alu_cmd;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic [31:0] disp;
    logic        busy;
    logic        halted;

    logic [31:0] mem [0:15];

    int tests = 0;
    int fails = 0;

    always #5 sys_clk = ~sys_clk;

    assign mem_data = mem[mem_addr[5:2]];

    always_comb begin
        alu_result = alu_a ^ alu_b;
        case (alu_cmd)
            F_ADD: alu_result = alu_a + alu_b;
            F_SUB: alu_result = alu_a - alu_b;
            F_AND: alu_result = alu_a & alu_b;
            F_OR:  alu_result = alu_a | alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
    end

    step_ctrl #(.MEM_SIZE(64)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .tick       (tick),
        .run        (run),
        .step       (step),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .alu_cmd    (alu_cmd),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .pc         (pc),
        .disp       (disp),
        .busy       (busy),
        .halted     (halted)
    );

    function automatic logic [31:0] enc(input logic [1:0] op, input logic [4:0] fn,
                                        input logic [2:0] rd, input logic [2:0] rs1,
                                        input logic [2:0] rs2, input logic [15:0] imm);
        return {op, fn, rd, rs1, rs2, imm};
    endfunction

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst = 1'b0;
        cyc();
        sys_rst = 1'b1;
        cyc();
    endtask

    // Start pulse then wait until the instruction is back in IDLE (N+4).
    task automatic one_instr();
        step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        sys_rst = 1'b0;
        cyc();
        cyc();
        tests++; if (pc !== 32'd0) begin fails++; $display("FAIL reset_pc: got %0h expected 0", pc); end
        tests++; if (mem_addr !== 32'd0) begin fails++; $display("FAIL reset_mem_addr: got %0h expected 0", mem_addr); end
        tests++; if (disp !== 32'd0) begin fails++; $display("FAIL reset_disp: got %0h expected 0", disp); end
        tests++; if ({alu_cmd, alu_a, alu_b} !== 69'd0) begin fails++; $display("FAIL reset_alu: got cmd %0h a %0h b %0h expected 0", alu_cmd, alu_a, alu_b); end
        tests++; if ({busy, halted} !== 2'b00) begin fails++; $display("FAIL reset_flags: got busy %b halted %b expected 0 0", busy, halted); end
        sys_rst = 1'b1;
        cyc();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle: got busy %b expected 0", busy); end
    endtask

    task automatic test_imm_add();
        step = 1'b1;
        cyc();
        step = 1'b0;
        tests++; if ({busy, alu_b} !== {1'b1, 32'd0}) begin fails++; $display("FAIL imm_fetch: got busy %b alu_b %0h expected 1 0", busy, alu_b); end
        cyc();
        tests++; if ({alu_cmd, alu_a, alu_b} !== {F_ADD, 32'd0, 32'd5}) begin fails++; $display("FAIL imm_exec: got cmd %0h a %0h b %0h expected 0 0 5", alu_cmd, alu_a, alu_b); end
        cyc();
        cyc();
        tests++; if ({disp, pc, busy} !== {32'd5, 32'd4, 1'b0}) begin fails++; $display("FAIL imm_done: got disp %0h pc %0h busy %b expected 5 4 0", disp, pc, busy); end
    endtask

    task automatic test_reg_reg();
        one_instr();
        tests++; if ({disp, pc} !== {32'd7, 32'd8}) begin fails++; $display("FAIL rr_r2: got disp %0h pc %0h expected 7 8", disp, pc); end
        step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
        tests++; if ({alu_a, alu_b} !== {32'd5, 32'd7}) begin fails++; $display("FAIL rr_exec: got a %0h b %0h expected 5 7", alu_a, alu_b); end
        cyc();
        cyc();
        tests++; if ({disp, pc} !== {32'd12, 32'd12}) begin fails++; $display("FAIL rr_add: got disp %0h pc %0h expected c c", disp, pc); end
        one_instr();
        tests++; if ({disp, pc} !== {32'd7, 32'd16}) begin fails++; $display("FAIL rr_sub: got disp %0h pc %0h expected 7 10", disp, pc); end
        one_instr();
        tests++; if ({disp, pc} !== {32'd7, 32'd20}) begin fails++; $display("FAIL rr_r0_write: got disp %0h pc %0h expected 7 14", disp, pc); end
    endtask

    task automatic test_jump();
        logic [31:0] exp_pc1;
        logic [31:0] exp_pc2;
`ifdef STEP_CTRL_BRANCH_EN
        exp_pc1 = 32'h20;
        exp_pc2 = 32'h0;
`else
        exp_pc1 = 32'd24;
        exp_pc2 = 32'd28;
`endif
        step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
        tests++; if ({alu_cmd, alu_a, alu_b} !== {F_ADD, 32'd0, 32'd99}) begin fails++; $display("FAIL jmp_alu_hold: got cmd %0h a %0h b %0h expected 0 0 63", alu_cmd, alu_a, alu_b); end
        cyc();
        cyc();
        tests++; if ({pc, disp} !== {exp_pc1, 32'd7}) begin fails++; $display("FAIL jmp_0x22: got pc %0h disp %0h expected %0h 7", pc, disp, exp_pc1); end
        one_instr();
        tests++; if (pc !== exp_pc2) begin fails++; $display("FAIL jmp_0x100: got pc %0h expected %0h", pc, exp_pc2); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            mem[i] = enc(2'b01, F_ADD, 3'd0, 3'd0, 3'd0, 16'h1234);
        end
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL tick_no_run: got busy %b expected 0", busy); end
        run = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tests++; if (pc !== 32'(i * 4)) begin fails++; $display("FAIL wrap_pc_%0d: got %0h expected %0h", i, pc, i * 4); end
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            repeat (9) cyc();
        end
        tests++; if ({pc, disp} !== {32'd0, 32'd0}) begin fails++; $display("FAIL wrap_end: got pc %0h disp %0h expected 0 0", pc, disp); end
    endtask

    task automatic test_same_cycle();
        step = 1'b1;
        tick = 1'b1;
        cyc();
        step = 1'b0;
        tick = 1'b0;
        cyc();
        cyc();
        cyc();
        tests++; if ({pc, busy} !== {32'd4, 1'b0}) begin fails++; $display("FAIL same_cycle: got pc %0h busy %b expected 4 0", pc, busy); end
        repeat (4) cyc();
        tests++; if (pc !== 32'd4) begin fails++; $display("FAIL same_cycle_once: got pc %0h expected 4", pc); end
        run = 1'b0;
    endtask

    task automatic test_drop_abort();
        do_reset();
        mem[0] = enc(2'b01, F_ADD, 3'd1, 3'd0, 3'd0, 16'd9);
        mem[1] = enc(2'b01, F_ADD, 3'd1, 3'd0, 3'd0, 16'd3);
        step = 1'b1;
        cyc();
        cyc();
        cyc();
        step = 1'b0;
        cyc();
        tests++; if ({disp, pc} !== {32'd9, 32'd4}) begin fails++; $display("FAIL drop_first: got disp %0h pc %0h expected 9 4", disp, pc); end
        repeat (4) cyc();
        tests++; if ({pc, busy} !== {32'd4, 1'b0}) begin fails++; $display("FAIL drop_no_second: got pc %0h busy %b expected 4 0", pc, busy); end
        step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
        cyc();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_in_wb: got busy %b expected 1", busy); end
        sys_rst = 1'b0;
        #1;
        tests++; if ({pc, disp, busy} !== {32'd0, 32'd0, 1'b0}) begin fails++; $display("FAIL abort_async: got pc %0h disp %0h busy %b expected 0 0 0", pc, disp, busy); end
        cyc();
        sys_rst = 1'b1;
        mem[0] = enc(2'b00, F_ADD, 3'd4, 3'd1, 3'd0, 16'd0);
        step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
        tests++; if (alu_a !== 32'd0) begin fails++; $display("FAIL abort_r1: got r1 %0h expected 0", alu_a); end
        cyc();
        cyc();
        tests++; if (pc !== 32'd4) begin fails++; $display("FAIL abort_after: got pc %0h expected 4", pc); end
    endtask

    task automatic test_halt();
        do_reset();
        mem[0] = enc(2'b01, F_ADD, 3'd1, 3'd0, 3'd0, 16'd1);
        mem[1] = enc(2'b01, F_OR,  3'd2, 3'd0, 3'd0, 16'd2);
        mem[2] = enc(2'b11, F_ADD, 3'd3, 3'd1, 3'd2, 16'd0);
        one_instr();
        one_instr();
        tests++; if ({pc, disp} !== {32'd8, 32'd2}) begin fails++; $display("FAIL halt_pre: got pc %0h disp %0h expected 8 2", pc, disp); end
        step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_early: got halted %b expected 0", halted); end
        cyc();
        tests++; if ({halted, busy, pc} !== {1'b1, 1'b0, 32'd8}) begin fails++; $display("FAIL halt_enter: got halted %b busy %b pc %0h expected 1 0 8", halted, busy, pc); end
        step = 1'b1;
        run  = 1'b1;
        tick = 1'b1;
        repeat (3) cyc();
        step = 1'b0;
        run  = 1'b0;
        tick = 1'b0;
        repeat (3) cyc();
        tests++; if ({halted, busy, pc, disp} !== {1'b1, 1'b0, 32'd8, 32'd2}) begin fails++; $display("FAIL halt_absorb: got halted %b busy %b pc %0h disp %0h expected 1 0 8 2", halted, busy, pc, disp); end
        sys_rst = 1'b0;
        #1;
        tests++; if ({pc, halted} !== {32'd0, 1'b0}) begin fails++; $display("FAIL halt_reset: got pc %0h halted %b expected 0 0", pc, halted); end
        cyc();
        sys_rst = 1'b1;
        cyc();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = 32'd0;
        end
        mem[0] = enc(2'b01, F_ADD, 3'd1, 3'd0, 3'd0, 16'd5);
        mem[1] = enc(2'b01, F_ADD, 3'd2, 3'd0, 3'd0, 16'd7);
        mem[2] = enc(2'b00, F_ADD, 3'd3, 3'd1, 3'd2, 16'd0);
        mem[3] = enc(2'b00, F_SUB, 3'd4, 3'd3, 3'd1, 16'd0);
        mem[4] = enc(2'b01, F_ADD, 3'd0, 3'd0, 3'd0, 16'd99);
        mem[5] = enc(2'b10, 5'h1F, 3'd5, 3'd3, 3'd1, 16'h0022);
        mem[6] = enc(2'b10, 5'h1F, 3'd5, 3'd3, 3'd1, 16'h0100);
        mem[8] = enc(2'b10, 5'h1F, 3'd5, 3'd3, 3'd1, 16'h0100);

        test_reset();
        test_imm_add();
        test_reg_reg();
        test_jump();
        test_wrap();
        test_same_cycle();
        test_drop_abort();
        test_halt();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/step_ctrl.md
# step_ctrl

Instruction sequencer for the demo computer's datapath. It fetches 32-bit words from the word-addressed program memory at `pc` and drives the shared ALU. It holds an 8-entry register file and writes results back. Each instruction is started by a run tick from the clock divider or by a single-step button pulse. It replaces the free-running `pc` stepper and feeds `disp` to the seven-segment driver.

## Interface
- `MEM_SIZE`, 64: program memory size in bytes; `pc` wraps to 0 past `MEM_SIZE-1`.
- `sys_clk`  in  1  system clock; all state updates on the rising edge.
- `sys_rst`  in  1  reset, asynchronous, active-low.
- `tick`  in  1  one-cycle pulse from the clock divider.
- `run`  in  1  level; 1 = start an instruction on every `tick`.
- `step`  in  1  one-cycle debounced button pulse; starts one instruction regardless of `run`.
- `mem_addr`  out  32  equals `pc`.
- `mem_data`  in  32  combinational read data for `mem_addr`.
- `alu_cmd`  out  5  ALU function code.
- `alu_a`, `alu_b`  out  32 each  ALU operands.
- `alu_result`  in  32  combinational ALU output.
- `pc`  out  32  current byte address, always a multiple of 4.
- `disp`  out  32  last value written to a nonzero register.
- `busy`  out  1  high in FETCH, EXEC and WB.
- `halted`  out  1  high in HALT.

## Operation
- Instruction fields:
  - op `[31:30]`: 00 = reg-reg ALU, 01 = reg-imm ALU, 10 = jump, 11 = halt.
  - fn `[29:25]`: value driven on `alu_cmd`.
  - rd `[24:22]`, rs1 `[21:19]`, rs2 `[18:16]`.
  - imm `[15:0]`: zero-extended.
- Register file `r0..r7`, 32 bits each. `r0` always reads 0, and writes to it are dropped.
- State machine:
  - IDLE: on `step | (run & tick)` → FETCH.
  - FETCH: latch `mem_data` into the instruction register → EXEC.
  - EXEC: drive `alu_cmd` = fn, `alu_a` = rs1 value, `alu_b` = rs2 value (op 00) or imm (op 01), then latch `alu_result`.
    - op 00/01 → WB.
    - op 10 → WB; ALU outputs hold their previous values.
    - op 11 → HALT.
  - WB:
    - op 00/01: write rd and update `disp` if rd≠0.
    - op 00/01: pc ← pc+4, or 0 if pc+4 > MEM_SIZE-1.
    - op 10: pc ← imm & ~3, or 0 if that value ≥ MEM_SIZE.
    - Then → IDLE.
  - HALT: absorbing; only reset leaves it. `step`, `tick` and `run` are ignored.
- Start pulses arriving while `busy` or `halted` are dropped, not queued.
- Same-cycle `step` and `tick` in IDLE start exactly one instruction.
- Arithmetic: `pc` increments modulo the wrap rule above. ALU width is 32 bits and carries are discarded by the ALU.

## Timing
- Reset values: state IDLE; `pc`, `mem_addr`, `disp`, `alu_a`, `alu_b` = 0; `alu_cmd` = 0; `busy` = 0; `halted` = 0; all registers 0.
- Reset is asynchronous and may be asserted mid-instruction. The partial instruction is aborted with no register write and no `pc` change.
- Start pulse sampled in cycle N (IDLE):
  - FETCH in N+1.
  - EXEC in N+2.
  - WB in N+3.
  - IDLE in N+4, with the new `pc` and `disp` visible from N+4.
- Throughput: at most one instruction per 4 cycles. A start pulse in cycle N+4 is accepted.
- Halt: start in N, FETCH in N+1, EXEC in N+2, `halted` = 1 from N+3. `pc` stays on the halt word.
- `alu_*` outputs are registered and change only on entry to EXEC.

## Configuration
- `STEP_CTRL_BRANCH_EN` defined: op 10 performs the jump as described above.
- `STEP_CTRL_BRANCH_EN` not defined: op 10 is a NOP that takes WB with pc ← pc+4 (wrap rule applies) and writes no register.

## Test plan
- Reset, then one `step` with mem[0] = op 01, fn = F_ADD, rd = 1, rs1 = 0, imm = 5 → after 4 cycles r1 = 5, `disp` = 5, `pc` = 4, `busy` low.
- Reg-reg add: r1 = 5, r2 = 7, then op 00 F_ADD rd = 3, rs1 = 1, rs2 = 2 → `alu_a` = 5, `alu_b` = 7 in EXEC; `disp` = 12.
- Wrap: 16 NOP-like writes to r0 with `run` = 1 and `tick` every 10 cycles → `pc` sequence 0, 4, …, 60, 0; `disp` unchanged at 0.
- Jump with macro on: op 10, imm = 0x0022 → `pc` = 0x20. With imm = 0x0100 → `pc` = 0. With macro off, the same words give `pc` = old+4.
- Halt: op 11 at pc = 8, then further `step` pulses → `halted` = 1, `pc` stays 8, `busy` = 0. `sys_rst` low → `pc` = 0, `halted` = 0.
- Drop and abort: `step` pulses in FETCH and in EXEC → only one instruction executes. Assert `sys_rst` during WB → r1 not written, `pc` = 0 immediately.
